// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared 7-segment definitions. Holds the hex-to-pattern table
//               used by the encoder and by the scan reader. Both directions
//               use the same table, so they always agree. Also holds the FSM
//               state encoding and the depth of the input synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Number of flops in the input synchronizer chain
    localparam int c_sync_stages = 2;

    // Pattern for nibble k is c_seg7_table[k]; bit order is gfedcba,
    // active-high. Entry 15 is written first.
    localparam logic [15:0][6:0] c_seg7_table = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Scan reader FSM states
    typedef logic [0:0] seg7_state_t;
    localparam seg7_state_t c_st_sync    = 1'b0;
    localparam seg7_state_t c_st_collect = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational reverse lookup of a 7-segment pattern. It
//               searches the shared table for an exact match.
// Ports       : i_pattern  7-bit segment pattern (gfedcba)
//               o_nibble   decoded hex nibble (0 when o_hit is low)
//               o_hit      high when i_pattern matches a table entry exactly
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_nibble,
    output logic       o_hit
);

    // The table entries are all distinct, so at most one entry matches
    always_comb begin
        o_nibble = 4'h0;
        o_hit    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (i_pattern == c_seg7_table[k]) begin
                o_nibble = 4'(k);
                o_hit    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_reader
// Description : Watches a scanned, multiplexed 7-segment bus. It samples each
//               digit once the digit is stable and decodes it back to a hex
//               nibble. When a whole frame is captured, it publishes the frame
//               as one value with a one-cycle valid strobe.
// Ports       : clk      clock
//               rst      synchronous active-high reset
//               seg      segment lines, bit0=a .. bit6=g, active-high
//               an       one-hot digit enables, active-high
//               value    published frame, digit i in [4i+3:4i]
//               valid    one-cycle strobe when value updates
//               err      one-cycle strobe on an accepted invalid pattern
//               timeout  one-cycle strobe when a frame is abandoned
//               locked   high while collecting a frame
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic                  valid,
    output logic                  err,
    output logic                  timeout,
    output logic                  locked
);

    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_cnt_w = $clog2(STABLE_CYCLES + 1);
    localparam int c_tmo_w = $clog2(TIMEOUT);
    localparam int c_bus_w = DIGITS + 7;

    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_fire = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
    localparam logic [DIGITS-1:0]  c_one      = DIGITS'(1);
    localparam logic [DIGITS-1:0]  c_full     = '1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [c_sync_stages-1:0][c_bus_w-1:0] r_sync;
    logic [c_bus_w-1:0]                    r_prev;
    logic [c_cnt_w-1:0]                    r_stable_cnt;
    logic [c_tmo_w-1:0]                    r_tmo_cnt;
    seg7_state_t                           r_state;
    logic [DIGITS-1:0]                     r_mask;
    logic [4*DIGITS-1:0]                   r_slots;
    logic [4*DIGITS-1:0]                   r_value;
    logic                                  r_valid;
    logic                                  r_err;
    logic                                  r_timeout;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [c_bus_w-1:0]  w_sample;
    logic [DIGITS-1:0]   w_an;
    logic [6:0]          w_seg;
    logic                w_onehot;
    logic                w_same;
    logic                w_accept;
    logic [c_idx_w-1:0]  w_idx;
    logic [3:0]          w_nibble;
    logic                w_hit;
    logic                w_capture;
    seg7_state_t         w_state_next;
    logic [DIGITS-1:0]   w_mask_next;
    logic [4*DIGITS-1:0] w_slots_next;
    logic [4*DIGITS-1:0] w_value_next;
    logic                w_valid_next;
    logic                w_err_next;
    logic                w_timeout_next;

    assign w_sample = r_sync[c_sync_stages-1];
    assign w_an     = w_sample[c_bus_w-1:7];
    assign w_seg    = w_sample[6:0];
    assign w_onehot = (w_an != '0) && ((w_an & (w_an - c_one)) == '0);
    assign w_same   = (w_sample == r_prev);

    // Fires exactly once per stable run: the counter saturates at
    // STABLE_CYCLES, so it passes through the fire value only once.
    assign w_accept = w_onehot && w_same && (r_stable_cnt == c_cnt_fire);

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_an[k]) begin
                w_idx = c_idx_w'(k);
            end
        end
    end

    seg7_pattern_decode u_decode (
        .i_pattern (w_seg),
        .o_nibble  (w_nibble),
        .o_hit     (w_hit)
    );

    // ------------------------------------------------------------------------
    // Input synchronizer and stability filter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= '0;
            r_prev       <= '0;
            r_stable_cnt <= '0;
        end else begin
            r_sync <= {r_sync[c_sync_stages-2:0], {an, seg}};
            r_prev <= w_sample;
            if (!w_onehot || !w_same) begin
                r_stable_cnt <= '0;
            end else if (r_stable_cnt != c_cnt_max) begin
                r_stable_cnt <= r_stable_cnt + c_cnt_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: state and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_sync;
            r_mask    <= '0;
            r_slots   <= '0;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mask    <= w_mask_next;
            r_slots   <= w_slots_next;
            r_value   <= w_value_next;
            r_valid   <= w_valid_next;
            r_err     <= w_err_next;
            r_timeout <= w_timeout_next;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_mask_next    = r_mask;
        w_slots_next   = r_slots;
        w_value_next   = r_value;
        w_valid_next   = 1'b0;
        w_err_next     = 1'b0;
        w_timeout_next = 1'b0;
        w_capture      = 1'b0;

        case (r_state)
            c_st_sync: begin
                // Only a good digit 0 can start a frame
                if (w_accept && w_hit && (w_idx == '0)) begin
                    w_capture    = 1'b1;
                    w_mask_next  = '0;
                    w_state_next = c_st_collect;
                end
            end
            c_st_collect: begin
                // An accept wins over an expiry in the same cycle
                if (w_accept) begin
                    if (w_hit) begin
                        w_capture = 1'b1;
                    end else begin
                        w_err_next   = 1'b1;
                        w_mask_next  = '0;
                        w_state_next = c_st_sync;
                    end
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_timeout_next = 1'b1;
                    w_mask_next    = '0;
                    w_state_next   = c_st_sync;
                end
            end
            default: begin
                w_mask_next  = '0;
                w_state_next = c_st_sync;
            end
        endcase

        if (w_capture) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (w_idx == c_idx_w'(k)) begin
                    w_slots_next[4*k +: 4] = w_nibble;
                    w_mask_next[k]         = 1'b1;
                end
            end
            if (w_mask_next == c_full) begin
                w_value_next = w_slots_next;
                w_valid_next = 1'b1;
                w_mask_next  = '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Inactivity timer. It counts only while collecting, and it restarts on
    // every accept.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != c_st_collect) || w_accept || w_timeout_next) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
    end

    assign value   = r_value;
    assign valid   = r_valid;
    assign err     = r_err;
    assign timeout = r_timeout;
    assign locked  = (r_state == c_st_collect);

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_reader
// Description : Self-checking bench for seg7_scan_reader. The stimulus is a
//               series of digit holds (an, seg, length). An event-level model
//               decides, for each stable run, whether and when a digit is
//               accepted. It then derives the frame results from those
//               accepts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_reader;

    localparam int c_digits  = 4;
    localparam int c_stable  = 4;
    localparam int c_timeout = 1024;
    // A run of pin values is accepted 2 sync + STABLE + 1 cycles after it
    // starts, provided the run lasts at least STABLE + 1 cycles.
    localparam int c_acc_lat = 2 + c_stable + 1;
    localparam int c_min_run = c_stable + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [6:0]            seg;
    logic [c_digits-1:0]   an;
    logic [4*c_digits-1:0] value;
    logic                  valid;
    logic                  err;
    logic                  timeout;
    logic                  locked;

    always #5 clk = ~clk;

    seg7_scan_reader #(
        .DIGITS        (c_digits),
        .STABLE_CYCLES (c_stable),
        .TIMEOUT       (c_timeout)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .an      (an),
        .value   (value),
        .valid   (valid),
        .err     (err),
        .timeout (timeout),
        .locked  (locked)
    );

    typedef struct {
        int          t;
        logic [3:0]  a;
        logic [6:0]  s;
    } acc_t;

    acc_t pend[$];

    logic [6:0] pat_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int errors = 0;
    int t = 0;
    int n_valid, n_err, n_tmo;
    int t_last_valid, t_last_tmo;
    int t_mark;

    // model state
    logic [15:0] m_value = '0;
    logic [15:0] m_slots = '0;
    logic [3:0]  m_mask  = '0;
    logic        m_locked = 1'b0;
    int          m_last = 0;
    logic        e_valid, e_err, e_tmo;

    // current pin run
    logic [10:0] cur_val = '0;
    int          run_start = 0;
    bit          run_sched = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_edge();
        acc_t       ev;
        logic       hit;
        logic [3:0] nib;
        int         idx;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_tmo   = 1'b0;
        if (rst) begin
            m_value  = '0;
            m_slots  = '0;
            m_mask   = '0;
            m_locked = 1'b0;
            pend.delete();
        end else if (pend.size() > 0 && pend[0].t == t) begin
            ev  = pend.pop_front();
            hit = 1'b0;
            nib = 4'h0;
            idx = 0;
            for (int k = 0; k < 16; k++) begin
                if (ev.s == pat_tab[k]) begin
                    hit = 1'b1;
                    nib = 4'(k);
                end
            end
            for (int i = 0; i < c_digits; i++) begin
                if (ev.a[i]) idx = i;
            end
            m_last = t;
            if (!m_locked) begin
                if (hit && idx == 0) begin
                    m_slots[3:0] = nib;
                    m_mask       = 4'b0001;
                    m_locked     = 1'b1;
                end
            end else if (!hit) begin
                e_err    = 1'b1;
                m_mask   = '0;
                m_locked = 1'b0;
            end else begin
                m_slots[4*idx +: 4] = nib;
                m_mask[idx]         = 1'b1;
            end
            if (m_locked && m_mask == 4'hF) begin
                m_value = m_slots;
                e_valid = 1'b1;
                m_mask  = '0;
            end
        end else if (m_locked && (t - m_last) == c_timeout) begin
            e_tmo    = 1'b1;
            m_mask   = '0;
            m_locked = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        @(negedge clk);
        model_edge();
        chk("value", 32'(value), 32'(m_value));
        chk("valid", 32'(valid), 32'(e_valid));
        chk("err", 32'(err), 32'(e_err));
        chk("timeout", 32'(timeout), 32'(e_tmo));
        chk("locked", 32'(locked), 32'(m_locked));
        if (valid === 1'b1) begin
            n_valid++;
            t_last_valid = t;
        end
        if (err === 1'b1) n_err++;
        if (timeout === 1'b1) begin
            n_tmo++;
            t_last_tmo = t;
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int len);
        for (int k = 0; k < len; k++) begin
            an  = a;
            seg = s;
            if ({a, s} != cur_val) begin
                cur_val   = {a, s};
                run_start = t;
                run_sched = 1'b0;
            end
            tick();
            if (!run_sched && (t - run_start) >= c_min_run) begin
                run_sched = 1'b1;
                if ($onehot(a)) pend.push_back('{t: run_start + c_acc_lat, a: a, s: s});
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'h0, 7'h00, 1);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        rst = 1'b1;
        an  = '0;
        seg = '0;
        n_valid = 0; n_err = 0; n_tmo = 0;
        t_last_valid = 0; t_last_tmo = 0; t_mark = 0;

        // reset state
        drive(4'h0, 7'h00, 3);
        rst = 1'b0;
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);

        // frame 0,1,2,3
        n_valid = 0; n_err = 0;
        drive(4'h1, 7'h3F, 10);
        drive(4'h2, 7'h06, 10);
        drive(4'h4, 7'h5B, 10);
        t_mark = t;
        drive(4'h8, 7'h4F, 10);
        chk("s1_valid_count", 32'(n_valid), 32'd1);
        chk("s1_latency", 32'(t_last_valid - t_mark), 32'd7);
        chk("s1_value", 32'(value), 32'h3210);
        chk("s1_err_count", 32'(n_err), 32'd0);

        // frames E,F,A,b then E,C,A,b
        n_valid = 0;
        drive(4'h1, 7'h79, 10);
        drive(4'h2, 7'h71, 10);
        drive(4'h4, 7'h77, 10);
        drive(4'h8, 7'h7C, 10);
        chk("s2_value_a", 32'(value), 32'hBAFE);
        drive(4'h1, 7'h79, 10);
        drive(4'h2, 7'h39, 10);
        drive(4'h4, 7'h77, 10);
        drive(4'h8, 7'h7C, 10);
        chk("s2_value_b", 32'(value), 32'hBACE);
        chk("s2_valid_count", 32'(n_valid), 32'd2);

        // invalid pattern on digit 1
        n_err = 0;
        drive(4'h1, 7'h3F, 10);
        chk("s4_locked_before", 32'(locked), 32'h1);
        drive(4'h2, 7'h00, 10);
        chk("s4_err_count", 32'(n_err), 32'd1);
        chk("s4_locked_after", 32'(locked), 32'h0);
        chk("s4_value_kept", 32'(value), 32'hBACE);

        // holds too short to be accepted
        n_valid = 0;
        for (int r = 0; r < 2; r++) begin
            drive(4'h1, 7'h3F, 3);
            drive(4'h2, 7'h06, 3);
            drive(4'h4, 7'h5B, 3);
            drive(4'h8, 7'h4F, 3);
        end
        chk("s3_valid_count", 32'(n_valid), 32'd0);
        chk("s3_locked", 32'(locked), 32'h0);

        // inactivity timeout
        n_tmo = 0;
        t_mark = t;
        drive(4'h1, 7'h3F, 10);
        drive(4'h0, 7'h00, 1100);
        chk("s5_tmo_count", 32'(n_tmo), 32'd1);
        chk("s5_tmo_delay", 32'(t_last_tmo - (t_mark + c_acc_lat)), 32'd1024);
        chk("s5_locked", 32'(locked), 32'h0);

        // reset mid-frame
        drive(4'h1, 7'h3F, 10);
        drive(4'h2, 7'h06, 10);
        drive(4'h0, 7'h00, 8);
        chk("s6_locked_mid", 32'(locked), 32'h1);
        do_reset();
        chk("s6_value_rst", 32'(value), 32'h0);
        chk("s6_locked_rst", 32'(locked), 32'h0);
        n_valid = 0;
        drive(4'h4, 7'h5B, 10);
        drive(4'h8, 7'h4F, 10);
        chk("s6_sync_ignored", 32'(locked), 32'h0);
        drive(4'h1, 7'h3F, 10);
        drive(4'h2, 7'h06, 10);
        drive(4'h4, 7'h5B, 10);
        drive(4'h8, 7'h4F, 10);
        chk("s6_valid_count", 32'(n_valid), 32'd1);
        chk("s6_value", 32'(value), 32'h3210);

        // randomized holds
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) ra = 4'($urandom);
            else                           ra = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rs = 7'($urandom);
            else                           rs = pat_tab[$urandom_range(0, 15)];
            drive(ra, rs, $urandom_range(2, 12));
        end
        drive(4'h0, 7'h00, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
